// File: rtl/range_stats_if.sv
// range_stats_if: sample stream and result bundle for range_stats.
// go/finish framing: a sequence opens on the cycle go is first seen high
// in IDLE or ERROR. Every cycle of the sequence presents one sample on
// data_in. The cycle with finish high carries the last sample. There is
// no back-pressure: the engine accepts a sample every cycle it is in RUN.
// done marks the single cycle after the finish edge when the results
// update. state_dbg exposes the FSM state (0 IDLE, 1 RUN, 2 ERROR).
interface range_stats_if #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
);
  logic                 go;
  logic                 finish;
  logic [WIDTH-1:0]     data_in;
  logic [WIDTH-1:0]     min_out;
  logic [WIDTH-1:0]     max_out;
  logic [WIDTH:0]       range;
  logic [CNT_WIDTH-1:0] count;
  logic                 done;
  logic                 busy;
  logic                 error;
  logic [1:0]           state_dbg;

  modport master (
    output go, finish, data_in,
    input  min_out, max_out, range, count, done, busy, error, state_dbg
  );

  modport slave (
    input  go, finish, data_in,
    output min_out, max_out, range, count, done, busy, error, state_dbg
  );
endinterface

// File: rtl/range_stats.sv
// range_stats: streaming min/max/range engine with go/finish framing.
// Optional feature macro: RANGE_STATS_COUNT_EN builds the saturating
// sample counter; without it count is tied to 0.
module range_stats #(
  parameter int WIDTH     = 8,
  parameter bit SIGNED    = 1'b0,
  parameter int CNT_WIDTH = 8
) (
  input  logic         clock,
  input  logic         reset,
  range_stats_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_ERROR = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             go_q;
  logic             load;
  logic             take;
  logic             publish;
  logic [WIDTH-1:0] cur_min;
  logic [WIDTH-1:0] cur_max;
  logic [WIDTH-1:0] inc_min;
  logic [WIDTH-1:0] inc_max;
  logic [WIDTH-1:0] min_q;
  logic [WIDTH-1:0] max_q;
  logic [WIDTH:0]   range_q;
  logic             done_q;
  logic             busy_q;
  logic             error_q;

  // a < b under the selected compare mode
  function automatic logic less_than(input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b);
    if (SIGNED) return $signed(a) < $signed(b);
    else        return a < b;
  endfunction

  // Widen by one bit so max - min never overflows and stays non-negative
  function automatic logic [WIDTH:0] widen(input logic [WIDTH-1:0] a);
    if (SIGNED) return {a[WIDTH-1], a};
    else        return {1'b0, a};
  endfunction

  // Next-state decode; finish wins over a go re-assertion in RUN
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    take      = 1'b0;
    publish   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.finish) begin
          state_nxt = S_ERROR;
        end else if (bus.go) begin
          load      = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.finish) begin
          take      = 1'b1;
          publish   = 1'b1;
          state_nxt = S_IDLE;
        end else if (bus.go && !go_q) begin
          state_nxt = S_ERROR;
        end else begin
          take = 1'b1;
        end
      end
      S_ERROR: begin
        if (bus.go && !bus.finish) begin
          load      = 1'b1;
          state_nxt = S_RUN;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Running extremes with the current sample; equal values keep the old one
  always_comb begin
    inc_min = less_than(bus.data_in, cur_min) ? bus.data_in : cur_min;
    inc_max = less_than(cur_max, bus.data_in) ? bus.data_in : cur_max;
  end

  // FSM state, go history and running extremes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      go_q    <= 1'b0;
      cur_min <= '0;
      cur_max <= '0;
    end else begin
      state <= state_nxt;
      go_q  <= bus.go;
      if (load) begin
        cur_min <= bus.data_in;
        cur_max <= bus.data_in;
      end else if (take) begin
        cur_min <= inc_min;
        cur_max <= inc_max;
      end
    end
  end

  // Registered results and status; results hold until the next publish
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      min_q   <= '0;
      max_q   <= '0;
      range_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      done_q  <= publish;
      busy_q  <= (state_nxt == S_RUN);
      error_q <= (state_nxt == S_ERROR);
      if (publish) begin
        min_q   <= inc_min;
        max_q   <= inc_max;
        range_q <= widen(inc_max) - widen(inc_min);
      end
    end
  end

`ifdef RANGE_STATS_COUNT_EN
  logic [CNT_WIDTH-1:0] cur_cnt;
  logic [CNT_WIDTH-1:0] inc_cnt;
  logic [CNT_WIDTH-1:0] count_q;

  // Saturating increment so long sequences pin at all-ones
  always_comb begin
    inc_cnt = (cur_cnt == {CNT_WIDTH{1'b1}}) ? cur_cnt : cur_cnt + CNT_WIDTH'(1);
  end

  // Running sample count and its published copy
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_cnt <= '0;
      count_q <= '0;
    end else begin
      if (load) begin
        cur_cnt <= CNT_WIDTH'(1);
      end else if (take) begin
        cur_cnt <= inc_cnt;
      end
      if (publish) begin
        count_q <= inc_cnt;
      end
    end
  end

  assign bus.count = count_q;
`else
  assign bus.count = '0;
`endif

  assign bus.min_out   = min_q;
  assign bus.max_out   = max_q;
  assign bus.range     = range_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.error     = error_q;
  assign bus.state_dbg = state;

endmodule
